ir_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 16-bit accumulator CPU.
- Holds PC and IR, and drives the 12-bit address of the combinational instruction memory.
- Decodes the 4-bit opcode and field [11:0], then issues one-hot ACC/ALU and data-memory strobes to the datapath.
- Sits between the instruction memory, the data memory and the accumulator datapath.

---
 rtl/ir_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ir_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_sequencer.sv
// ----------------------------------------------------------------------------
// ir_sequencer
//   Multi-cycle fetch/decode/execute controller for the 16-bit accumulator CPU.
//   Holds PC and IR, addresses the combinational instruction memory, decodes
//   the 4-bit opcode plus 12-bit field and issues one-cycle ACC/ALU and
//   data-memory strobes to the datapath.
//
//   Optional build macro: IR_SEQ_STEP_EN
//     Adds the 'step' input and a PAUSE state entered after each instruction
//     (except STP); a step pulse resumes fetching.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : one-cycle pulse, leaves IDLE/HALT and fetches from RESET_PC
//   step     : (IR_SEQ_STEP_EN only) releases PAUSE
//   ins      : instruction word for address ir_addr (same cycle)
//   acc_neg  : ACC[15], used by BAN
//   ir_addr  : instruction-memory address (PC)
//   dm_addr  : data-memory address (IR[11:0])
//   dm_re    : data-memory read strobe, data valid next cycle
//   dm_we    : data-memory write strobe (datapath writes ACC)
//   acc_clr/acc_com/acc_shr/acc_csl/acc_ld/acc_add : ACC operation strobes
//   halted   : high in HALT
//   illegal  : one-cycle pulse on an undefined opcode
//   state    : current FSM state (debug)
// ----------------------------------------------------------------------------
module ir_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef IR_SEQ_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] ins,
    input  logic        acc_neg,
    output logic [11:0] ir_addr,
    output logic [11:0] dm_addr,
    output logic        dm_re,
    output logic        dm_we,
    output logic        acc_clr,
    output logic        acc_com,
    output logic        acc_shr,
    output logic        acc_csl,
    output logic        acc_ld,
    output logic        acc_add,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state
);

    localparam int OP_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
`ifdef IR_SEQ_STEP_EN
        ,
        PAUSE  = 3'd6
`endif
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_CLA = 4'h0,
        OP_COM = 4'h1,
        OP_SHR = 4'h2,
        OP_CSL = 4'h3,
        OP_STP = 4'h4,
        OP_ADD = 4'h5,
        OP_STA = 4'h6,
        OP_LDA = 4'h7,
        OP_JMP = 4'h8,
        OP_BAN = 4'h9
    } op_t;

    // Where every instruction except STP goes after its last cycle.
`ifdef IR_SEQ_STEP_EN
    localparam state_t AFTER_INSTR = PAUSE;
`else
    localparam state_t AFTER_INSTR = FETCH;
`endif

    state_t           state_q, state_d;
    logic [11:0]      pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [OP_W-1:0]  opcode;
    logic [11:0]      field;

    assign opcode = ir_q[15 -: OP_W];
    assign field  = ir_q[11:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state / PC / IR update and strobe decode. Strobes depend only on
    // registered state and IR, so they are glitch-free and mutually exclusive.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dm_re   = 1'b0;
        dm_we   = 1'b0;
        acc_clr = 1'b0;
        acc_com = 1'b0;
        acc_shr = 1'b0;
        acc_csl = 1'b0;
        acc_ld  = 1'b0;
        acc_add = 1'b0;
        illegal = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                end
            end

            FETCH: begin
                ir_d    = ins;
                pc_d    = pc_q + 12'd1;
                state_d = DECODE;
            end

            DECODE: begin
                state_d = EXEC;
            end

            EXEC: begin
                state_d = AFTER_INSTR;
                case (opcode)
                    OP_CLA: acc_clr = 1'b1;
                    OP_COM: acc_com = 1'b1;
                    OP_SHR: acc_shr = 1'b1;
                    OP_CSL: acc_csl = 1'b1;
                    OP_STP: state_d = HALT;
                    OP_ADD: begin
                        dm_re   = 1'b1;
                        state_d = WB;
                    end
                    OP_STA: dm_we = 1'b1;
                    OP_LDA: begin
                        dm_re   = 1'b1;
                        state_d = WB;
                    end
                    OP_JMP: pc_d = field;
                    // PC already points past the BAN, so the offset is
                    // applied to PC-1 to make it relative to the BAN itself.
                    OP_BAN: begin
                        if (acc_neg) begin
                            pc_d = pc_q - 12'd1 + field;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end

            WB: begin
                if (opcode == OP_ADD) begin
                    acc_add = 1'b1;
                end else begin
                    acc_ld = 1'b1;
                end
                state_d = AFTER_INSTR;
            end

`ifdef IR_SEQ_STEP_EN
            PAUSE: begin
                if (step) begin
                    state_d = FETCH;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    assign ir_addr = pc_q;
    assign dm_addr = field;
    assign halted  = (state_q == HALT);
    assign state   = state_q;

endmodule

// File: tb/tb_ir_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ir_sequencer
//   Scoreboard bench for ir_sequencer. An instruction-level model walks the
//   program held in a behavioural instruction memory and pushes one expected
//   output record per clock cycle; a monitor pops and compares a record on
//   every falling edge. Build with +define+IR_SEQ_STEP_EN to exercise PAUSE.
// ----------------------------------------------------------------------------
module tb_ir_sequencer;

    localparam logic [11:0] RESET_PC = 12'h000;

    // Strobe vector bit order: clr com shr csl ld add re we
    localparam logic [7:0] S_CLR = 8'h80;
    localparam logic [7:0] S_COM = 8'h40;
    localparam logic [7:0] S_SHR = 8'h20;
    localparam logic [7:0] S_CSL = 8'h10;
    localparam logic [7:0] S_LD  = 8'h08;
    localparam logic [7:0] S_ADD = 8'h04;
    localparam logic [7:0] S_RE  = 8'h02;
    localparam logic [7:0] S_WE  = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        acc_neg;
`ifdef IR_SEQ_STEP_EN
    logic        step;
`endif
    logic [15:0] ins;
    logic [11:0] ir_addr, dm_addr;
    logic        dm_re, dm_we, acc_clr, acc_com, acc_shr, acc_csl, acc_ld, acc_add;
    logic        halted, illegal;
    logic [2:0]  state;

    always #5 clk = ~clk;

    logic [15:0] imem [4096];
    assign ins = imem[ir_addr];

    ir_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef IR_SEQ_STEP_EN
        .step    (step),
`endif
        .ins     (ins),
        .acc_neg (acc_neg),
        .ir_addr (ir_addr),
        .dm_addr (dm_addr),
        .dm_re   (dm_re),
        .dm_we   (dm_we),
        .acc_clr (acc_clr),
        .acc_com (acc_com),
        .acc_shr (acc_shr),
        .acc_csl (acc_csl),
        .acc_ld  (acc_ld),
        .acc_add (acc_add),
        .halted  (halted),
        .illegal (illegal),
        .state   (state)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] ia;
        logic [11:0] da;
        logic [7:0]  stb;
        logic        hl;
        logic        il;
    } rec_t;

    rec_t        exp_q[$];
    bit          startv[int];
    bit          rstv[int];
    bit          negv[int];
    bit          stepv[int];
    int          pcyc = 0;
    int          dcyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Architectural model: PC, IR and run mode (0 idle, 1 running, 5 halted).
    logic [11:0] m_pc;
    logic [15:0] m_ir;
    logic [2:0]  m_st;
    int          force_neg = -1;

    function automatic bit rnd_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit rnd_start();
        return ($urandom_range(0, 4) == 0);
    endfunction

    function automatic rec_t mk(input logic [2:0] st, input logic [7:0] stb, input logic il);
        rec_t r;
        r.st  = st;
        r.ia  = m_pc;
        r.da  = m_ir[11:0];
        r.stb = stb;
        r.hl  = (st == 3'd5);
        r.il  = il;
        return r;
    endfunction

    task automatic emit(input rec_t r, input bit s, input bit rs, input bit ng, input bit sp);
        exp_q.push_back(r);
        startv[pcyc] = s;
        rstv[pcyc]   = rs;
        negv[pcyc]   = ng;
        stepv[pcyc]  = sp;
        pcyc++;
    endtask

    task automatic plan_reset();
        m_pc = RESET_PC;
        m_ir = '0;
        m_st = 3'd0;
        emit(mk(3'd0, 8'h00, 1'b0), 1'b0, 1'b0, rnd_bit(), 1'b0);
    endtask

    // n idle/halt cycles; optionally start is pulsed in the last one.
    task automatic plan_wait(input int n, input bit last_start);
        for (int i = 0; i < n; i++) begin
            emit(mk(m_st, 8'h00, 1'b0), last_start && (i == n - 1), 1'b1, rnd_bit(), 1'b0);
        end
        if (last_start) begin
            m_pc = RESET_PC;
            m_st = 3'd1;
        end
    endtask

    // One instruction at m_pc. abort_at >= 0 replaces that cycle of the
    // instruction (0 fetch, 1 decode, 2 exec, 3 wb) with an async reset.
    task automatic plan_instr(input int abort_at);
        logic [15:0] w;
        logic [3:0]  op;
        logic [7:0]  stb;
        bit          ng;
        if (abort_at == 0) begin plan_reset(); return; end
        emit(mk(3'd1, 8'h00, 1'b0), rnd_start(), 1'b1, rnd_bit(), 1'b0);
        w    = imem[m_pc];
        m_ir = w;
        m_pc = m_pc + 12'd1;
        if (abort_at == 1) begin plan_reset(); return; end
        emit(mk(3'd2, 8'h00, 1'b0), rnd_start(), 1'b1, rnd_bit(), 1'b0);
        if (abort_at == 2) begin plan_reset(); return; end
        op = w[15:12];
        ng = (force_neg < 0) ? rnd_bit() : (force_neg != 0);
        case (op)
            4'h0:    stb = S_CLR;
            4'h1:    stb = S_COM;
            4'h2:    stb = S_SHR;
            4'h3:    stb = S_CSL;
            4'h5:    stb = S_RE;
            4'h6:    stb = S_WE;
            4'h7:    stb = S_RE;
            default: stb = 8'h00;
        endcase
        emit(mk(3'd3, stb, op >= 4'hA), rnd_start(), 1'b1, ng, 1'b0);
        if (op == 4'h8) m_pc = w[11:0];
        else if (op == 4'h9 && ng) m_pc = (m_pc - 12'd1) + w[11:0];
        if (op == 4'h4) begin
            m_st = 3'd5;
            return;
        end
        if (op == 4'h5 || op == 4'h7) begin
            if (abort_at == 3) begin plan_reset(); return; end
            emit(mk(3'd4, (op == 4'h5) ? S_ADD : S_LD, 1'b0), rnd_start(), 1'b1, rnd_bit(), 1'b0);
        end
`ifdef IR_SEQ_STEP_EN
        repeat ($urandom_range(0, 2)) emit(mk(3'd6, 8'h00, 1'b0), rnd_start(), 1'b1, rnd_bit(), 1'b0);
        emit(mk(3'd6, 8'h00, 1'b0), rnd_start(), 1'b1, rnd_bit(), 1'b1);
`endif
    endtask

    task automatic new_test();
        plan_reset();
        plan_wait(1, 1'b1);
    endtask

    // Apply planned inputs just after each rising edge.
    task automatic run_planned();
        while (dcyc < pcyc) begin
            @(posedge clk);
            #1;
            rst_n   = rstv[dcyc];
            start   = startv[dcyc];
            acc_neg = negv[dcyc];
`ifdef IR_SEQ_STEP_EN
            step    = stepv[dcyc];
`endif
            dcyc++;
        end
    endtask

    always @(negedge clk) begin
        rec_t e;
        rec_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.st  = state;
            a.ia  = ir_addr;
            a.da  = dm_addr;
            a.stb = {acc_clr, acc_com, acc_shr, acc_csl, acc_ld, acc_add, dm_re, dm_we};
            a.hl  = halted;
            a.il  = illegal;
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle%0d: got st=%0d pc=%h dm=%h stb=%b halt=%b ill=%b, want st=%0d pc=%h dm=%h stb=%b halt=%b ill=%b",
                         n_vec - 1, a.st, a.ia, a.da, a.stb, a.hl, a.il,
                         e.st, e.ia, e.da, e.stb, e.hl, e.il);
            end
        end
    end

    initial begin
        int ab;
        rst_n   = 1'b0;
        start   = 1'b0;
        acc_neg = 1'b0;
`ifdef IR_SEQ_STEP_EN
        step    = 1'b0;
`endif
        for (int unsigned i = 0; i < 4096; i++) imem[i] = 16'hA000;
        m_pc = RESET_PC;
        m_ir = '0;
        m_st = 3'd0;

        // CLA at 0, then an undefined opcode at 1
        imem[0] = 16'h0000;
        plan_reset();
        plan_reset();
        plan_wait(2, 1'b1);
        plan_instr(-1);
        plan_instr(-1);
        run_planned();

        // LDA 0, ADD 1
        imem[0] = 16'h7000;
        imem[1] = 16'h5001;
        new_test();
        plan_instr(-1);
        plan_instr(-1);
        run_planned();

        // JMP 7 -> JMP 9 -> BAN 2 taken -> STP at 11, then restart
        imem[0]  = 16'h8007;
        imem[7]  = 16'h8009;
        imem[9]  = 16'h9002;
        imem[11] = 16'h4000;
        new_test();
        force_neg = 1;
        repeat (4) plan_instr(-1);
        force_neg = -1;
        plan_wait(3, 1'b1);
        plan_instr(-1);
        run_planned();

        // BAN not taken at 9; BAN 0xFFF at 0 taken wraps; NOP-class at 0xFFF wraps
        imem[0]    = 16'h8009;
        imem[9]    = 16'h9002;
        imem[10]   = 16'hA000;
        imem[11]   = 16'h4000;
        new_test();
        plan_instr(-1);
        force_neg = 0;
        plan_instr(-1);
        force_neg = -1;
        plan_instr(-1);
        run_planned();
        imem[0]     = 16'h9FFF;
        imem[12'hFFF] = 16'hB123;
        new_test();
        force_neg = 1;
        plan_instr(-1);
        force_neg = -1;
        plan_instr(-1);
        force_neg = 0;
        plan_instr(-1);
        force_neg = -1;
        run_planned();

        // Reset during LDA write-back, then a clean LDA
        imem[0] = 16'h7055;
        new_test();
        plan_instr(3);
        plan_wait(1, 1'b1);
        plan_instr(-1);
        run_planned();

        // Random program with occasional mid-instruction resets
        for (int unsigned i = 0; i < 4096; i++) imem[i] = 16'($urandom);
        new_test();
        for (int k = 0; k < 400; k++) begin
            if (m_st != 3'd1) plan_wait(int'($urandom_range(1, 3)), 1'b1);
            ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1;
            plan_instr(ab);
        end
        run_planned();

        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d unchecked records, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
